// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// frame-engine states and the baud divisor / parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  // Rounded clock-per-bit count.
  function automatic int baud_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // The word is zero-extended to 9 bits, so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input logic [1:0] mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^word);
      PAR_EVEN: p = ^word;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the buffered UART transmitter: push strobe, data,
// and the FIFO status fed back to the producer.
interface uart_tx_fifo_if #(
  parameter int DataBits  = 8,
  parameter int FifoDepth = 16
);
  localparam int LevelW = $clog2(FifoDepth) + 1;

  logic                TxD_start;
  logic [DataBits-1:0] TxD_data;
  logic                TxD_full;
  logic [LevelW-1:0]   TxD_level;

  modport master (output TxD_start, output TxD_data, input TxD_full, input TxD_level);
  modport slave  (input TxD_start, input TxD_data, output TxD_full, output TxD_level);
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read register array.
// Contents are not reset; the pointers in the parent define what is valid.
module uart_tx_fifo_mem #(
  parameter int Width = 8,
  parameter int Depth = 16,
  parameter int AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  // Store the pushed word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO pointers/level plus a frame engine that
// serialises queued words back-to-back with configurable width, parity and stops.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 100000000,
  parameter int Baud         = 115200,
  parameter int DataBits     = 8,
  parameter int Parity       = 0,
  parameter int StopBits     = 1,
  parameter int FifoDepth    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_fifo_if.slave        tx,
  output logic                 TxD_busy,
  output logic                 TxD
);

  localparam int         Divisor = baud_divisor(ClkFrequency, Baud);
  localparam int         AddrW   = $clog2(FifoDepth);
  localparam int         LevelW  = AddrW + 1;
  localparam int         CntW    = $clog2(Divisor);
  localparam logic [1:0] ParMode = Parity[1:0];

  if (ClkFrequency < 8 * Baud) begin : g_err_clk
    $error("uart_tx_fifo: ClkFrequency must be at least 8*Baud");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_err_bits
    $error("uart_tx_fifo: DataBits must be 5..9");
  end
  if (Parity < 0 || Parity > 2) begin : g_err_par
    $error("uart_tx_fifo: Parity must be 0, 1 or 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_err_stop
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_err_depth
    $error("uart_tx_fifo: FifoDepth must be a power of 2, at least 2");
  end

  tx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]   level_q, level_d;

  logic                full_s;
  logic                have_s;
  logic                push_s;
  logic                pop_s;
  logic                bit_end_s;
  logic                start_frame_s;
  logic                end_frame_s;
  logic [DataBits-1:0] head_s;

  assign full_s    = (level_q == LevelW'(FifoDepth));
  assign have_s    = (level_q != {LevelW{1'b0}});
  assign push_s    = tx.TxD_start & ~full_s;
  assign bit_end_s = (cnt_q == CntW'(Divisor - 1));

  uart_tx_fifo_mem #(
    .Width (DataBits),
    .Depth (FifoDepth),
    .AddrW (AddrW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (tx.TxD_data),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  // Frame engine next state; outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CntW'(1);
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    txd_d         = txd_q;
    busy_d        = busy_q;
    pop_s         = 1'b0;
    start_frame_s = 1'b0;
    end_frame_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d         = {CntW{1'b0}};
        start_frame_s = have_s;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = {CntW{1'b0}};
          txd_d   = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d   = {CntW{1'b0}};
          shift_d = shift_q >> 1;
          if (bitcnt_q == 4'(DataBits - 1)) begin
            if (ParMode != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP1;
              txd_d   = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
            txd_d    = shift_q[1];
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP1;
          cnt_d   = {CntW{1'b0}};
          txd_d   = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (bit_end_s) begin
          if (StopBits == 2) begin
            state_d = ST_STOP2;
            cnt_d   = {CntW{1'b0}};
            txd_d   = 1'b1;
          end else begin
            end_frame_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (bit_end_s) begin
          end_frame_s = 1'b1;
        end else begin
          state_d = ST_STOP2;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CntW{1'b0}};
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A queued word at the end of a frame starts the next one with no idle gap.
    if (end_frame_s) begin
      if (have_s) begin
        start_frame_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = {CntW{1'b0}};
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    end else begin
      end_frame_s = 1'b0;
    end

    if (start_frame_s) begin
      pop_s    = 1'b1;
      shift_d  = head_s;
      par_d    = parity_bit(9'(head_s), ParMode);
      bitcnt_d = 4'd0;
      cnt_d    = {CntW{1'b0}};
      state_d  = ST_START;
      txd_d    = 1'b0;
      busy_d   = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO pointers and occupancy; a dropped push never touches them.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CntW{1'b0}};
      bitcnt_q <= 4'd0;
      shift_q  <= {DataBits{1'b0}};
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= {AddrW{1'b0}};
      rd_ptr_q <= {AddrW{1'b0}};
      level_q  <= {LevelW{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign tx.TxD_full  = full_s;
  assign tx.TxD_level = level_q;
  assign TxD          = txd_q;
  assign TxD_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations at Divisor=10, frames
// checked at the first and last cycle of every bit against hand-built bit strings.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk;
  logic rst_n;
  logic rst3_n;
  logic txd0, txd1, txd2, txd3;
  logic busy0, busy1, busy2, busy3;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_fifo_if #(.DataBits(8), .FifoDepth(16)) if0 ();
  uart_tx_fifo_if #(.DataBits(8), .FifoDepth(16)) if1 ();
  uart_tx_fifo_if #(.DataBits(7), .FifoDepth(16)) if2 ();
  uart_tx_fifo_if #(.DataBits(8), .FifoDepth(4))  if3 ();

  uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DataBits(8), .Parity(0),
                 .StopBits(1), .FifoDepth(16))
    dut0 (.clk(clk), .rst_n(rst_n), .tx(if0), .TxD_busy(busy0), .TxD(txd0));
  uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DataBits(8), .Parity(2),
                 .StopBits(2), .FifoDepth(16))
    dut1 (.clk(clk), .rst_n(rst_n), .tx(if1), .TxD_busy(busy1), .TxD(txd1));
  uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DataBits(7), .Parity(1),
                 .StopBits(1), .FifoDepth(16))
    dut2 (.clk(clk), .rst_n(rst_n), .tx(if2), .TxD_busy(busy2), .TxD(txd2));
  uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DataBits(8), .Parity(0),
                 .StopBits(1), .FifoDepth(4))
    dut3 (.clk(clk), .rst_n(rst3_n), .tx(if3), .TxD_busy(busy3), .TxD(txd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_txd(input int sel);
    case (sel)
      0:       return txd0;
      1:       return txd1;
      2:       return txd2;
      default: return txd3;
    endcase
  endfunction

  // bits holds the frame first-bit-leftmost; off is how far into the frame we already are.
  task automatic check_frame(input int sel, input logic [15:0] bits, input int len,
                             input int off, input string tag);
    for (int c = off; c < len * 10; c++) begin
      if ((c % 10) == 0 || (c % 10) == 9) begin
        check_value($sformatf("%s bit%0d cyc%0d", tag, c / 10, c % 10),
                    32'(get_txd(sel)), 32'(bits[len - 1 - c / 10]));
      end
      step();
    end
  endtask

  logic [15:0] f4 [5];
  logic        seen_activity;

  initial begin
    f4[0] = 16'b0100000001;
    f4[1] = 16'b0010000001;
    f4[2] = 16'b0110000001;
    f4[3] = 16'b0001000001;
    f4[4] = 16'b0101000001;
    if0.TxD_start = 1'b0; if0.TxD_data = 8'h00;
    if1.TxD_start = 1'b0; if1.TxD_data = 8'h00;
    if2.TxD_start = 1'b0; if2.TxD_data = 7'h00;
    if3.TxD_start = 1'b0; if3.TxD_data = 8'h00;
    rst_n = 1'b0; rst3_n = 1'b0;
    step(); step();
    rst_n = 1'b1; rst3_n = 1'b1;
    step();

    check_value("rst TxD0",   32'(txd0), 32'd1);
    check_value("rst busy0",  32'(busy0), 32'd0);
    check_value("rst full0",  32'(if0.TxD_full), 32'd0);
    check_value("rst level0", 32'(if0.TxD_level), 32'd0);
    check_value("rst TxD3",   32'(txd3), 32'd1);
    check_value("rst busy3",  32'(busy3), 32'd0);
    check_value("rst full3",  32'(if3.TxD_full), 32'd0);
    check_value("rst level3", 32'(if3.TxD_level), 32'd0);

    // 8N1 single word, 2-cycle latency
    if0.TxD_data = 8'hA5; if0.TxD_start = 1'b1;
    step();
    if0.TxD_start = 1'b0;
    check_value("t1 level N+1", 32'(if0.TxD_level), 32'd1);
    check_value("t1 TxD N+1",   32'(txd0), 32'd1);
    check_value("t1 busy N+1",  32'(busy0), 32'd0);
    step();
    check_value("t1 busy N+2",  32'(busy0), 32'd1);
    check_frame(0, 16'b0101001011, 10, 0, "t1");
    check_value("t1 busy after",  32'(busy0), 32'd0);
    check_value("t1 TxD after",   32'(txd0), 32'd1);
    check_value("t1 level after", 32'(if0.TxD_level), 32'd0);

    // 8E2
    if1.TxD_data = 8'h07; if1.TxD_start = 1'b1;
    step();
    if1.TxD_start = 1'b0;
    step();
    check_frame(1, 16'b011100000111, 12, 0, "t2");
    check_value("t2 busy after", 32'(busy1), 32'd0);

    // 7O1, two contiguous frames
    if2.TxD_data = 7'h00; if2.TxD_start = 1'b1;
    step();
    if2.TxD_data = 7'h7F;
    step();
    if2.TxD_start = 1'b0;
    check_frame(2, 16'b0000000011, 10, 0, "t3a");
    check_frame(2, 16'b0111111101, 10, 0, "t3b");
    check_value("t3 busy after", 32'(busy2), 32'd0);

    // Depth-4 burst of six strobes, last dropped
    for (int k = 0; k < 6; k++) begin
      if3.TxD_data = 8'(k + 1); if3.TxD_start = 1'b1;
      if (k >= 1) begin
        check_value($sformatf("t4 level c%0d", k), 32'(if3.TxD_level),
                    (k == 1) ? 32'd1 : 32'(k - 1));
      end
      check_value($sformatf("t4 full c%0d", k), 32'(if3.TxD_full), (k == 5) ? 32'd1 : 32'd0);
      step();
    end
    if3.TxD_start = 1'b0;
    check_value("t4 level c6", 32'(if3.TxD_level), 32'd4);
    check_frame(3, f4[0], 10, 4, "t4 f1");
    for (int k = 1; k < 5; k++) begin
      check_frame(3, f4[k], 10, 0, $sformatf("t4 f%0d", k + 1));
    end
    check_value("t4 busy after",  32'(busy3), 32'd0);
    check_value("t4 level after", 32'(if3.TxD_level), 32'd0);

    // Reset during data bit 3 with two words queued
    if3.TxD_data = 8'h00; if3.TxD_start = 1'b1;
    step(); step(); step();
    if3.TxD_start = 1'b0;
    for (int k = 0; k < 42; k++) step();
    check_value("t5 TxD pre",   32'(txd3), 32'd0);
    check_value("t5 level pre", 32'(if3.TxD_level), 32'd2);
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    check_value("t5 TxD post",   32'(txd3), 32'd1);
    check_value("t5 level post", 32'(if3.TxD_level), 32'd0);
    check_value("t5 busy post",  32'(busy3), 32'd0);
    seen_activity = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (txd3 !== 1'b1 || busy3 !== 1'b0) seen_activity = 1'b1;
      step();
    end
    check_value("t5 quiet", 32'(seen_activity), 32'd0);

    // Strobe while full in the same cycle as a pop
    for (int k = 0; k < 5; k++) begin
      if3.TxD_data = 8'(8'h11 + k); if3.TxD_start = 1'b1;
      step();
    end
    if3.TxD_start = 1'b0;
    check_value("t6 level full", 32'(if3.TxD_level), 32'd4);
    check_value("t6 full",       32'(if3.TxD_full), 32'd1);
    for (int k = 0; k < 96; k++) step();
    if3.TxD_data = 8'h3C; if3.TxD_start = 1'b1;
    check_value("t6 level at pop", 32'(if3.TxD_level), 32'd4);
    check_value("t6 full at pop",  32'(if3.TxD_full), 32'd1);
    step();
    if3.TxD_start = 1'b0;
    check_value("t6 level after pop", 32'(if3.TxD_level), 32'd3);
    check_frame(3, 16'b0010010001, 10, 0, "t6 f2");
    for (int k = 0; k < 300; k++) step();
    check_value("t6 busy drained",  32'(busy3), 32'd0);
    check_value("t6 level drained", 32'(if3.TxD_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
